// File: rtl/seq_div_pkg.sv
// seq_div_pkg: state encoding and counter sizing shared by the sequential divider
package seq_div_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/sub_borrow_unit.sv
// sub_borrow_unit: combinational ripple-borrow subtractor a-b
module sub_borrow_unit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         bout
);
  logic [N:0] br;
  assign br[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign bout = br[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one trial subtraction per clock
// Optional macro SEQ_DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
import seq_div_pkg::*;

module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] p, q, d, q_n, p_n;
  logic [WIDTH:0] s, t;
  logic [CW-1:0] cnt;
  logic bout, restore, accept, last, dz;
  // P's top bit is always zero between iterations, so only the low WIDTH bits are stored
  assign s = {p, q[WIDTH-1]};
  sub_borrow_unit #(.N(WIDTH + 1)) u_sub (
    .a   (s),
    .b   ({1'b0, d}),
    .diff(t),
    .bout(bout)
  );
  assign restore = bout | t[WIDTH];
  assign p_n     = restore ? s[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_n     = {q[WIDTH-2:0], ~restore};
  assign accept  = start & (state == S_IDLE);
  assign last    = cnt == CW'(1);
`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign dz = divisor == '0;
`else
  assign dz = 1'b0;
`endif
  always_comb begin
    state_n = state == S_IDLE ? (start ? (dz ? S_DONE : S_CALC) : S_IDLE) :
              state == S_CALC ? (last ? S_DONE : S_CALC) : S_IDLE;
  end
  assign ready = state == S_IDLE;
  assign busy  = state == S_CALC;
  assign done  = state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        p        <= '0;
        q        <= dividend;
        d        <= divisor;
        cnt      <= CW'(WIDTH);
        div_zero <= dz;
        if (dz) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == S_CALC) begin
        p   <= p_n;
        q   <= q_n;
        cnt <= cnt - 1'b1;
        if (last) begin
          quotient  <= q_n;
          remainder <= p_n;
        end
      end
    end
  end
endmodule
